// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and constants for the PLL/DCM reset sequencer.
// Holds the sequencer state encoding and the lock-loss counter width.
package pll_reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ASSERT    = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int LOSS_CNT_W = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer that brings the asynchronous PLL lock into the
// reference clock domain; both stages clear on reset.
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Reset sequencer for a PLL/DCM: pulses pll_rst, waits for a stable lock and
// then releases sys_rst. Define PLL_LOCK_LOSS_COUNT_EN to build the lock-loss counter.
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_lock,
    input  logic                  relock_req,
    output logic                  pll_rst,
    output logic                  sys_rst,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lockS;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;

    pll_lock_sync u_lock_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (pll_lock),
        .sync_o  (lockS)
    );

    // Outputs are registered from the decoded current state, so sys_rst and
    // ready toggle on the same edge and can never glitch against each other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ASSERT;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ASSERT: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (relock_req)                  state_d = ASSERT;
                else if (lockS)                  state_d = STABLE;
                else if (cnt_q == TIMEOUT_LAST)  state_d = ASSERT;
            end
            STABLE: begin
                if (relock_req)                  state_d = ASSERT;
                else if (!lockS)                 state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST)   state_d = RUN;
            end
            RUN: begin
                if (relock_req || !lockS)        state_d = ASSERT;
            end
            default: state_d = ASSERT;
        endcase

        // One counter serves every state: it restarts on any transition and
        // parks at all-ones rather than wrapping while sitting in RUN.
        if (state_d != state_q)  cnt_d = '0;
        else if (cnt_q != '1)    cnt_d = cnt_q + CNT_W'(1);
    end

    always_comb begin
        pll_rst_d = (state_q == ASSERT);
        sys_rst_d = (state_q != RUN);
        ready_d   = (state_q == RUN);
    end

    assign pll_rst = pll_rst_q;
    assign sys_rst = sys_rst_q;
    assign ready   = ready_q;

`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] loss_q;
    logic                  lossEvent;

    // Only a lock drop seen in RUN counts; a simultaneous relock still counts once.
    assign lossEvent = (state_q == RUN) && !lockS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_q <= '0;
        end else if (lossEvent && (loss_q != LOSS_CNT_MAX)) begin
            loss_q <= loss_q + LOSS_CNT_W'(1);
        end
    end

    assign lock_loss_count = loss_q;
`else
    assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed sequences plus random
// lock/relock activity, all compared every cycle against a phase/countdown model.
module tb_pll_reset_sequencer;

    localparam int RST_CYC    = 4;
    localparam int TIMEOUT    = 100;
    localparam int STABLE_CYC = 20;
`ifdef PLL_LOCK_LOSS_COUNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       pll_lock   = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] lock_loss_count;

    int compareCount  = 0;
    int mismatchCount = 0;
    int cycleCount    = 0;
    bit checkOn       = 1'b0;

    pll_reset_sequencer #(
        .RST_CYCLES    (RST_CYC),
        .LOCK_TIMEOUT  (TIMEOUT),
        .STABLE_CYCLES (STABLE_CYC),
        .CNT_W         (17)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pll_lock        (pll_lock),
        .relock_req      (relock_req),
        .pll_rst         (pll_rst),
        .sys_rst         (sys_rst),
        .ready           (ready),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)",
                     tag, observed, expected, cycleCount);
        end
    endtask

    // Reference model: named phase with a countdown of cycles left in it,
    // plus a two-deep history of pll_lock standing in for the synchronizer.
    string mPhase    = "assert";
    int    mRemain   = RST_CYC;
    bit    mSyncA    = 1'b0;
    bit    mSyncB    = 1'b0;
    bit    mLockS    = 1'b0;
    int    mLoss     = 0;
    bit    expPllRst = 1'b1;
    bit    expSysRst = 1'b1;
    bit    expReady  = 1'b0;

    task automatic enterAssert();
        mPhase  = "assert";
        mRemain = RST_CYC;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            enterAssert();
            mSyncA    = 1'b0;
            mSyncB    = 1'b0;
            mLoss     = 0;
            expPllRst = 1'b1;
            expSysRst = 1'b1;
            expReady  = 1'b0;
        end else begin
            mLockS    = mSyncB;
            expPllRst = (mPhase == "assert");
            expSysRst = (mPhase != "run");
            expReady  = (mPhase == "run");
            if (mPhase == "assert") begin
                mRemain--;
                if (mRemain == 0) begin
                    mPhase  = "wait";
                    mRemain = TIMEOUT;
                end
            end else if (mPhase == "wait") begin
                if (relock_req) enterAssert();
                else if (mLockS) begin
                    mPhase  = "stable";
                    mRemain = STABLE_CYC;
                end else begin
                    mRemain--;
                    if (mRemain == 0) enterAssert();
                end
            end else if (mPhase == "stable") begin
                if (relock_req) enterAssert();
                else if (!mLockS) begin
                    mPhase  = "wait";
                    mRemain = TIMEOUT;
                end else begin
                    mRemain--;
                    if (mRemain == 0) mPhase = "run";
                end
            end else begin
                if (!mLockS && mLoss < 255) mLoss++;
                if (!mLockS || relock_req) enterAssert();
            end
            mSyncB = mSyncA;
            mSyncA = pll_lock;
        end
    end

    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("pll_rst", pll_rst, expPllRst);
            checkOutput("sys_rst", sys_rst, expSysRst);
            checkOutput("ready", ready, expReady);
            checkOutput("lock_loss_count", lock_loss_count, LOSS_EN ? mLoss : 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit lock, input bit relock);
        pll_lock   = lock;
        relock_req = relock;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic dropLock(input int n);
        applyStimulus(1'b0, 1'b0);
        tick(n);
        applyStimulus(1'b1, 1'b0);
    endtask

    task automatic waitReady(input int budget, output int waited);
        waited = 0;
        while (ready !== 1'b1 && waited < budget) begin
            tick(1);
            waited++;
        end
        if (ready !== 1'b1) checkOutput("readyTimeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached before the end of the run");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int rises[$];
        bit prevPllRst;
        bit sawReady;
        bit sawPllRst;
        bit lockState;

        @(posedge clk);
        #1;
        checkOn = 1'b1;
        checkOutput("rstPllRst", pll_rst, 1);
        checkOutput("rstSysRst", sys_rst, 1);
        checkOutput("rstReady", ready, 0);
        checkOutput("rstLossCount", lock_loss_count, 0);

        // Clean power-up with lock already present.
        applyStimulus(1'b1, 1'b0);
        tick(2);
        rst = 1'b0;
        waitReady(60, waited);
        checkOutput("lockToReady", (waited >= 24 && waited <= 28), 1);
        checkOutput("sysRstInRun", sys_rst, 0);

        // No lock at all: pll_rst pulses keep repeating and ready never rises.
        applyStimulus(1'b0, 1'b0);
        doReset();
        sawReady   = 1'b0;
        prevPllRst = pll_rst;
        for (int i = 0; i < 450; i++) begin
            tick(1);
            if (pll_rst && !prevPllRst) rises.push_back(cycleCount);
            if (ready) sawReady = 1'b1;
            prevPllRst = pll_rst;
        end
        checkOutput("retryRises", (rises.size() >= 3), 1);
        if (rises.size() >= 3) begin
            checkOutput("retryPeriod1", rises[1] - rises[0], RST_CYC + TIMEOUT);
            checkOutput("retryPeriod2", rises[2] - rises[1], RST_CYC + TIMEOUT);
        end
        checkOutput("readyWithoutLock", sawReady, 0);

        // Short lock glitch in the middle of the stability window.
        applyStimulus(1'b1, 1'b0);
        doReset();
        tick(14);
        dropLock(3);
        sawPllRst = 1'b0;
        waited    = 0;
        while (ready !== 1'b1 && waited < 80) begin
            tick(1);
            waited++;
            if (pll_rst) sawPllRst = 1'b1;
        end
        checkOutput("glitchNoPllRst", sawPllRst, 0);
        checkOutput("glitchReadyDelay", (waited >= 20 && waited <= 26), 1);

        // Three lock losses while running.
        doReset();
        waitReady(60, waited);
        for (int i = 0; i < 3; i++) begin
            dropLock(3);
            waitReady(100, waited);
        end
        checkOutput("lossAfter3", lock_loss_count, LOSS_EN ? 3 : 0);

        // Relock request landing in the same cycle as the synchronized lock drop.
        applyStimulus(1'b0, 1'b0);
        tick(2);
        applyStimulus(1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("lossRelockCombined", lock_loss_count, LOSS_EN ? 4 : 0);
        checkOutput("relockLeftRun", ready, 0);
        waitReady(100, waited);

        // Asynchronous reset while running.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRunReady", ready, 0);
        checkOutput("asyncRunSysRst", sys_rst, 1);
        checkOutput("asyncRunPllRst", pll_rst, 1);
        checkOutput("asyncRunLoss", lock_loss_count, 0);
        applyStimulus(1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Asynchronous reset while waiting for lock.
        tick(20);
        checkOutput("waitLockPllRstLow", pll_rst, 0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncWaitPllRst", pll_rst, 1);
        checkOutput("asyncWaitSysRst", sys_rst, 1);
        checkOutput("asyncWaitReady", ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Drive enough lock losses to saturate the counter.
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            waitReady(100, waited);
            dropLock(3);
        end
        waitReady(100, waited);
        checkOutput("lossSaturated", lock_loss_count, LOSS_EN ? 255 : 0);

        // Random lock toggling and relock requests.
        lockState = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) lockState = !lockState;
            applyStimulus(lockState, ($urandom_range(0, 79) == 0));
            tick(1);
        end
        applyStimulus(1'b1, 1'b0);
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
